sram_axi4_s: RTL and testbench
==============================

# sram_axi4_s

AXI4 slave wrapper around a word-addressed SRAM array; sits directly downstream of the SRAM AXI4 master traffic generator and services its read and write requests. Independent read and write channel FSMs drive a one-read/one-write array. Reads support INCR bursts terminated by `o_rlast`. Writes are single-beat with byte strobes.

## Interface
- `ADDR_W`, 8, word-address width; array depth is 2^ADDR_W.
- `DATA_W`, 64, data width; strobe width is DATA_W/8.
- `i_aclk` in 1: single clock, rising edge.
- `i_areset` in 1: reset, asynchronous, active-high.
- `i_araddr` in ADDR_W: read start word address.
- `i_arlen` in 8: beats minus one.
- `i_arvalid` in 1 / `o_arready` out 1: AR handshake.
- `o_rdata` out DATA_W: read beat data.
- `o_rresp` out 2: read response, always 2'b00 (OKAY).
- `o_rlast` out 1: final beat of the burst.
- `o_rvalid` out 1 / `i_rready` in 1: R handshake.
- `i_awaddr` in ADDR_W: write word address.
- `i_awvalid` in 1 / `o_awready` out 1: AW handshake.
- `i_wdata` in DATA_W: write data.
- `i_wstrb` in DATA_W/8: byte enables.
- `i_wvalid` in 1 / `o_wready` out 1: W handshake.
- `o_bresp` out 2: write response, always 2'b00.
- `o_bvalid` out 1 / `i_bready` in 1: B handshake.

## Operation
- Reset behaviour: while `i_areset` is high, every output is 0 and both FSMs are held in IDLE. `o_arready` and `o_awready` rise on the first `i_aclk` edge after reset deasserts (registered enable).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: `o_arready`=1. On `i_arvalid`&&`o_arready`:
    - latch addr←`i_araddr`, len←`i_arlen`, beat count←0;
    - load `o_rdata`←mem[`i_araddr`];
    - go to R_DATA.
  - R_DATA: `o_arready`=0, `o_rvalid`=1, `o_rlast`=(count==len). On `i_rready`:
    - if not last: addr←addr+1 (wraps mod 2^ADDR_W), count←count+1, `o_rdata`←mem[addr+1];
    - if last: go to R_IDLE.
  - `o_rdata`, `o_rvalid` and `o_rlast` hold stable while `i_rready` is low.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: `o_awready`=1. On AW handshake: latch addr, go to W_DATA.
  - W_DATA: `o_wready`=1. On W handshake: for each byte b with `i_wstrb[b]`=1, mem[addr] byte b←`i_wdata` byte b; then go to W_RESP.
  - W_RESP: `o_bvalid`=1, `o_bresp`=0. On `i_bready`: go to W_IDLE.
- Channel independence:
  - Read and write FSMs run concurrently; neither blocks the other.
  - AW and W are never accepted in the same cycle.
  - A W beat presented before the AW handshake waits; `o_wready` stays 0.
- Read/write collision: a read load and a write commit to the same word on the same edge return the pre-write data (read-first).
- Reset mid-burst: both FSMs return to IDLE immediately and the outstanding burst or response is dropped. Array contents are kept, except as stated under Configuration.

## Timing
- AR handshake at edge k: `o_rvalid`=1 and beat 0 data valid after edge k.
- Each `i_rready`-accepted beat at edge k: next beat valid after edge k. Sustained throughput is 1 beat/cycle.
- After the last beat is accepted at edge k: `o_arready`=1 after edge k. Minimum gap between bursts is 1 cycle.
- Write sequence:
  - AW accepted at edge k: `o_wready`=1 after edge k.
  - W accepted at edge k+n: the write commits at that edge and `o_bvalid`=1 after it.
  - The written data is readable by any read loaded at edge k+n+1 or later.
- Minimum write cycle (AW→W→B→next AW) is 3 cycles with `i_bready` held high.

## Configuration
- `SRAM_AXI4_S_PRELOAD_EN`:
  - Defined: while `i_areset` is high, mem[i]←i (zero-extended to DATA_W) for every word; this also applies on a reset asserted mid-operation.
  - Undefined: the array has no reset; contents are X until written.

## Test plan
- PRELOAD_EN defined, reset, AR addr=1 len=0, `i_rready`=1 → single beat rdata=1, rlast=1, rresp=0; arready back to 1 the next cycle.
- AW addr=1, W data=20 strb=8'hFF, bready=1 → bvalid for one cycle with bresp=0; then read addr=1 → 20.
- W data=64'hFFFF_FFFF_FFFF_FFFF strb=8'h0F to addr=2 (PRELOAD_EN, old=2) → read returns 64'h0000_0000_FFFF_FFFF.
- AR addr=254 len=3 with `i_rready` toggled 1,0,1,1,1 → beats 254,255,0,1 in order; data held during the stall; rlast only on beat 3.
- In one cycle, read loads addr 5 while W commits 99 to addr 5 → read returns old value 5; a subsequent read returns 99.
- Reset asserted mid-burst (beat 1 of 4) → rvalid/rlast drop to 0 asynchronously; arready=1 one edge after release; a new AR is accepted normally.

Source files
------------

// File: rtl/sram_axi4_s.sv
// sram_axi4_s: AXI4 slave over a 1R/1W word-addressed SRAM. INCR read bursts, single-beat strobed writes.
// Latency: R beat valid one cycle after AR/R handshake; B valid one cycle after W. R/B hold until accepted, W waits for AW.
// Build option SRAM_AXI4_S_PRELOAD_EN: while reset is high every word i is loaded with i.
module sram_axi4_s #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic                  i_aclk,
   input  logic                  i_areset,
   input  logic [ADDR_W-1:0]     i_araddr,
   input  logic [7:0]            i_arlen,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   output logic [DATA_W-1:0]     o_rdata,
   output logic [1:0]            o_rresp,
   output logic                  o_rlast,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   input  logic [ADDR_W-1:0]     i_awaddr,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wstrb,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   output logic [1:0]            o_bresp,
   output logic                  o_bvalid,
   input  logic                  i_bready
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic       {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   r_state_t          r_state;
   w_state_t          w_state;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] rd_addr_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        rd_len;
   logic [7:0]        rd_cnt;
   logic [7:0]        rd_cnt_nxt;
   logic              wr_en;

   assign rd_addr_nxt = rd_addr + ADDR_W'(1);
   assign rd_cnt_nxt  = rd_cnt + 8'd1;
   assign wr_en       = o_wready & i_wvalid;
   assign o_rresp     = 2'b00;
   assign o_bresp     = 2'b00;

   // Reads sample mem with the pre-edge value, so a same-edge write is not seen (read-first).
`ifdef SRAM_AXI4_S_PRELOAD_EN
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= DATA_W'(i);
      end else if (wr_en) begin
         for (int b = 0; b < STRB_W; b++)
            if (i_wstrb[b]) mem[wr_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end
`else
   always_ff @(posedge i_aclk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++)
            if (i_wstrb[b]) mem[wr_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
   end
`endif

   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_state   <= R_IDLE;
         o_arready <= 1'b0;
         o_rvalid  <= 1'b0;
         o_rlast   <= 1'b0;
         o_rdata   <= '0;
         rd_addr   <= '0;
         rd_len    <= '0;
         rd_cnt    <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               o_arready <= 1'b1;
               if (i_arvalid && o_arready) begin
                  rd_addr   <= i_araddr;
                  rd_len    <= i_arlen;
                  rd_cnt    <= '0;
                  o_rdata   <= mem[i_araddr];
                  o_rvalid  <= 1'b1;
                  o_rlast   <= (i_arlen == 8'd0);
                  o_arready <= 1'b0;
                  r_state   <= R_DATA;
               end
            end
            R_DATA: begin
               if (i_rready) begin
                  if (o_rlast) begin
                     o_rvalid  <= 1'b0;
                     o_rlast   <= 1'b0;
                     o_arready <= 1'b1;
                     r_state   <= R_IDLE;
                  end else begin
                     rd_addr <= rd_addr_nxt;
                     rd_cnt  <= rd_cnt_nxt;
                     o_rdata <= mem[rd_addr_nxt];
                     o_rlast <= (rd_cnt_nxt == rd_len);
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // AW and W never complete together: wready only rises after the AW edge.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         w_state   <= W_IDLE;
         o_awready <= 1'b0;
         o_wready  <= 1'b0;
         o_bvalid  <= 1'b0;
         wr_addr   <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               o_awready <= 1'b1;
               if (i_awvalid && o_awready) begin
                  wr_addr   <= i_awaddr;
                  o_awready <= 1'b0;
                  o_wready  <= 1'b1;
                  w_state   <= W_DATA;
               end
            end
            W_DATA: begin
               if (i_wvalid) begin
                  o_wready <= 1'b0;
                  o_bvalid <= 1'b1;
                  w_state  <= W_RESP;
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  o_bvalid  <= 1'b0;
                  o_awready <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_axi4_s.sv
// Scoreboard bench for sram_axi4_s: driver pushes expected R beats / B responses, negedge monitor pops and compares.
module tb_sram_axi4_s;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic          i_aclk = 1'b0;
   logic          i_areset = 1'b1;
   logic [AW-1:0] i_araddr = '0;
   logic [7:0]    i_arlen = '0;
   logic          i_arvalid = 1'b0;
   logic          o_arready;
   logic [DW-1:0] o_rdata;
   logic [1:0]    o_rresp;
   logic          o_rlast;
   logic          o_rvalid;
   logic          i_rready = 1'b0;
   logic [AW-1:0] i_awaddr = '0;
   logic          i_awvalid = 1'b0;
   logic          o_awready;
   logic [DW-1:0] i_wdata = '0;
   logic [SW-1:0] i_wstrb = '0;
   logic          i_wvalid = 1'b0;
   logic          o_wready;
   logic [1:0]    o_bresp;
   logic          o_bvalid;
   logic          i_bready = 1'b1;

   sram_axi4_s #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_aclk(i_aclk), .i_areset(i_areset),
      .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast), .o_rvalid(o_rvalid), .i_rready(i_rready),
      .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready)
   );

   always #5 i_aclk = ~i_aclk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } rbeat_t;

   int            n_checks = 0;
   int            n_fail = 0;
   int            b_pend = 0;
   logic [DW-1:0] model [256];
   rbeat_t        exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every accepted R beat and B response against the scoreboard.
   logic          stall_pend = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic          stall_last = 1'b0;
   always @(negedge i_aclk) begin
      rbeat_t e;
      if (!i_areset) begin
         if (stall_pend && o_rvalid) begin
            chk("r_hold_data", o_rdata, stall_data);
            chk("r_hold_last", 64'(o_rlast), 64'(stall_last));
         end
         if (o_rvalid && i_rready) begin
            if (exp_q.size() == 0) begin
               chk("r_unexpected_beat", 64'(o_rvalid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("r_data", o_rdata, e.data);
               chk("r_last", 64'(o_rlast), 64'(e.last));
               chk("r_resp", 64'(o_rresp), 64'd0);
            end
         end
         if (o_bvalid && i_bready) begin
            chk("b_resp", 64'(o_bresp), 64'd0);
            chk("b_expected", 64'(b_pend > 0), 64'd1);
            if (b_pend > 0) b_pend--;
         end
      end
      stall_pend = !i_areset && o_rvalid && !i_rready;
      stall_data = o_rdata;
      stall_last = o_rlast;
   end

   function automatic logic rdy(input int ch);
      case (ch)
         0:       return o_arready;
         1:       return o_awready;
         default: return o_wready;
      endcase
   endfunction

   // Returns one time unit after the edge on which the handshake completed.
   task automatic wait_rdy(input int ch);
      int n = 0;
      @(negedge i_aclk);
      while (!rdy(ch) && n < 50) begin
         @(negedge i_aclk);
         n++;
      end
      if (!rdy(ch)) chk($sformatf("handshake_timeout_ch%0d", ch), 64'(rdy(ch)), 64'd1);
      @(posedge i_aclk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input bit early_w);
      i_wdata = d;
      i_wstrb = s;
      if (early_w) begin
         i_wvalid = 1'b1;
         @(negedge i_aclk);
         chk("wready_before_aw", 64'(o_wready), 64'd0);
         @(posedge i_aclk);
         #1;
      end
      i_awaddr  = a;
      i_awvalid = 1'b1;
      wait_rdy(1);
      i_awvalid = 1'b0;
      i_wvalid  = 1'b1;
      wait_rdy(2);
      i_wvalid = 1'b0;
      for (int b = 0; b < SW; b++)
         if (s[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
      b_pend++;
      chk("bvalid_after_w", 64'(o_bvalid), 64'd1);
      @(posedge i_aclk);
      #1;
      chk("bvalid_one_cycle", 64'(o_bvalid), 64'd0);
      chk("awready_after_b", 64'(o_awready), 64'd1);
   endtask

   // Drives rready from mask bit per cycle (1 beyond bit 31) until len+1 beats are taken.
   task automatic consume(input int len, input logic [31:0] mask);
      int left = len + 1;
      int cyc = 0;
      while (left > 0 && cyc < 300) begin
         i_rready = (cyc < 32) ? mask[cyc] : 1'b1;
         @(negedge i_aclk);
         if (o_rvalid && i_rready) left--;
         @(posedge i_aclk);
         #1;
         cyc++;
      end
      i_rready = 1'b0;
      if (left > 0) chk("r_beats_timeout", 64'(left), 64'd0);
      chk("arready_after_last", 64'(o_arready), 64'd1);
      chk("rvalid_after_last", 64'(o_rvalid), 64'd0);
   endtask

   task automatic push_burst(input logic [AW-1:0] a, input int len);
      rbeat_t e;
      for (int i = 0; i <= len; i++) begin
         e.data = model[8'(int'(a) + i)];
         e.last = (i == len);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int len, input logic [31:0] mask);
      push_burst(a, len);
      i_araddr  = a;
      i_arlen   = 8'(len);
      i_arvalid = 1'b1;
      wait_rdy(0);
      i_arvalid = 1'b0;
      consume(len, mask);
   endtask

   initial begin
      rbeat_t e;
      int     n;
      repeat (3) @(posedge i_aclk);
      @(negedge i_aclk);
      chk("rst_arready", 64'(o_arready), 64'd0);
      chk("rst_awready", 64'(o_awready), 64'd0);
      chk("rst_wready", 64'(o_wready), 64'd0);
      chk("rst_rvalid", 64'(o_rvalid), 64'd0);
      chk("rst_rlast", 64'(o_rlast), 64'd0);
      chk("rst_bvalid", 64'(o_bvalid), 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      @(posedge i_aclk);
      #1;
      i_areset = 1'b0;
      chk("arready_before_edge", 64'(o_arready), 64'd0);
      @(posedge i_aclk);
      #1;
      chk("arready_after_edge", 64'(o_arready), 64'd1);
      chk("awready_after_edge", 64'(o_awready), 64'd1);

      // Fill every word with its own index so contents are known with or without preload.
      for (int i = 0; i < 256; i++) do_write(8'(i), 64'(i), 8'hFF, 1'b0);

      do_read(8'd1, 0, 32'hFFFF_FFFF);
      do_write(8'd1, 64'd20, 8'hFF, 1'b1);
      do_read(8'd1, 0, 32'hFFFF_FFFF);
      do_write(8'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
      do_read(8'd2, 0, 32'hFFFF_FFFF);
      do_read(8'd254, 3, 32'hFFFF_FFFD);

      // Read load of addr 5 on the same edge as a W commit to addr 5.
      i_awaddr  = 8'd5;
      i_awvalid = 1'b1;
      wait_rdy(1);
      i_awvalid = 1'b0;
      e.data = model[5];
      e.last = 1'b1;
      exp_q.push_back(e);
      i_araddr  = 8'd5;
      i_arlen   = 8'd0;
      i_arvalid = 1'b1;
      i_wdata   = 64'd99;
      i_wstrb   = 8'hFF;
      i_wvalid  = 1'b1;
      @(negedge i_aclk);
      chk("coll_arready", 64'(o_arready), 64'd1);
      chk("coll_wready", 64'(o_wready), 64'd1);
      @(posedge i_aclk);
      #1;
      i_arvalid = 1'b0;
      i_wvalid  = 1'b0;
      model[5]  = 64'd99;
      b_pend++;
      consume(0, 32'hFFFF_FFFF);
      do_read(8'd5, 0, 32'hFFFF_FFFF);

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(8'($urandom), {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 1)));
         else
            do_read(8'($urandom), $urandom_range(0, 7), $urandom);
      end

      // Reset asserted while beat 1 of a 4-beat burst is presented.
      push_burst(8'd10, 3);
      i_araddr  = 8'd10;
      i_arlen   = 8'd3;
      i_arvalid = 1'b1;
      wait_rdy(0);
      i_arvalid = 1'b0;
      i_rready  = 1'b1;
      @(negedge i_aclk);
      @(posedge i_aclk);
      #1;
      i_rready = 1'b0;
      #2;
      i_areset = 1'b1;
      #1;
      chk("midrst_rvalid", 64'(o_rvalid), 64'd0);
      chk("midrst_rlast", 64'(o_rlast), 64'd0);
      chk("midrst_arready", 64'(o_arready), 64'd0);
      exp_q.delete();
`ifdef SRAM_AXI4_S_PRELOAD_EN
      for (int i = 0; i < 256; i++) model[i] = 64'(i);
`endif
      @(posedge i_aclk);
      #1;
      i_areset = 1'b0;
      chk("midrst_arready_release", 64'(o_arready), 64'd0);
      @(posedge i_aclk);
      #1;
      chk("midrst_arready_edge", 64'(o_arready), 64'd1);
      do_read(8'd3, 1, 32'hFFFF_FFFF);
      do_read(8'd1, 0, 32'hFFFF_FFFF);

      n = 0;
      while ((exp_q.size() != 0 || b_pend != 0) && n < 20) begin
         @(posedge i_aclk);
         n++;
      end
      chk("scoreboard_r_empty", 64'(exp_q.size()), 64'd0);
      chk("scoreboard_b_empty", 64'(b_pend), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
